tracker_row_sequencer: RTL and testbench
========================================

Name: tracker_row_sequencer

Overview:
- Pattern sequencer that drives the DDS_Sine freq_word and a note gate from a row-based pattern memory, advancing one row every TEMPO sample ticks.
- Sits between the control/UI logic (sw or host writes) and the synth datapath (DDS_Sine → PCMSerializer).
- Runs entirely in the DDS clock domain.
- The 48 kHz sample rate arrives as a single-cycle sample_tick strobe already synchronised to clk.

Parameters:
- ROWS, 64: pattern length in rows; must be a power of 2, ≥ 2.
- ROW_W, $clog2(ROWS): row address width, derived; do not override.
- TEMPO_W, 16: width of the ticks-per-row input.

Ports:
- clk  in  1  system clock, same clock as DDS_Sine.
- rst_active_low  in  1  reset, synchronous, active-low.
- sample_tick  in  1  one-cycle strobe per audio sample (48 kHz).
- play  in  1  start pulse; honoured only in IDLE.
- stop  in  1  stop pulse; honoured in any state.
- tempo  in  TEMPO_W  sample ticks per row; sampled at each row start.
- wr_en  in  1  pattern write strobe.
- wr_addr  in  ROW_W  pattern write row.
- wr_data  in  8  pattern row word.
- freq_word  out  32  DDS phase increment.
- note_gate  out  1  high while a note sounds.
- row_idx  out  ROW_W  row currently applied.
- row_strobe  out  1  one-cycle pulse when a row is applied.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state = IDLE; freq_word = 0, note_gate = 0, row_idx = 0, row_strobe = 0, busy = 0; tick counter = 0. Pattern RAM contents are not cleared.
- Pattern RAM: ROWS × 8, one write port and one synchronous read port, 1-cycle read latency. If a write and a read hit the same address in the same cycle, the read returns the old data. Writes are allowed in every state.
- Row word decode:
  - 8'h00 = hold: no change to outputs.
  - 8'hFF = note-off: note_gate ← 0; freq_word unchanged.
  - bit7 = 1 with note n = [6:0], n ≠ 7F: note_gate ← 1; freq_word ← NOTE_INC[n].
  - bit7 = 0 and nonzero: reserved; treated as hold.
- FSM states: IDLE, FETCH, APPLY, WAIT.
  - IDLE → FETCH on play; row pointer ← 0.
  - FETCH: present the row pointer to the RAM read port; next state APPLY.
  - APPLY: decode the read data and register the outputs; row_idx ← row pointer; pulse row_strobe; load the tick counter with max(tempo, 1); next state WAIT.
  - WAIT: decrement the counter on each sample_tick. When the counter reaches 1 and a sample_tick arrives, row pointer increments (wrapping at ROWS) and the FSM goes to FETCH.
- Latency: play sampled at edge k → FETCH during cycle k+1 → outputs and row_strobe valid after edge k+3.
- tempo = 0 is treated as 1. A tempo change takes effect at the next row.
- stop: has priority over play and over every other transition. Next state = IDLE; note_gate ← 0; freq_word ← 0; row_idx is held; row_strobe ← 0.
- play while busy: ignored.
- sample_tick outside WAIT: ignored, not queued.
- End of pattern, after the last row (ROWS−1): see Optional Feature.
- Reset mid-operation: same result as the reset values above, within one cycle.

Optional Feature:
- Macro: SEQ_LOOP_EN.
- Defined: after row ROWS−1, the row pointer wraps to 0 and playback continues indefinitely until stop.
- Undefined: when the WAIT period of row ROWS−1 expires, the FSM goes to IDLE instead of FETCH. note_gate ← 0, freq_word ← 0, busy ← 0, and the FSM emits no further row_strobe.

Decomposition:
- Package tracker_pkg:
  - seq_state_t enum.
  - ROW_HOLD = 8'h00 and ROW_NOTE_OFF = 8'hFF constants.
  - NOTE_INC[0:127], a 32-bit localparam array: round(440·2^((n−69)/12)·2^32 / 100e6), generated offline for a 100 MHz clk.
- Sub-module pattern_ram: 1W/1R synchronous RAM holding the pattern. All FSM logic stays in tracker_row_sequencer.

Test Plan:
- Reset, then idle for 100 cycles → freq_word = 0, note_gate = 0, busy = 0, no row_strobe.
- Write row0 = 8'hC5 (note 69), row1 = 8'h00, row2 = 8'hFF; tempo = 2; pulse play → 3 cycles later freq_word = 32'h0000_49D2, gate = 1. After 2 sample_ticks row1 applies (unchanged outputs); after 2 more, row2 applies: gate = 0, freq_word still 32'h49D2.
- tempo = 0 → a new row applies after every sample_tick; row_strobe count equals tick count.
- ROWS = 4, tempo = 1, 5 ticks → with SEQ_LOOP_EN: row_idx sequence 0,1,2,3,0 and busy stays 1. Without it: busy drops after the 4th tick, and the 5th tick produces no row_strobe.
- stop and play asserted in the same cycle during WAIT → IDLE next cycle, gate = 0, freq_word = 0; a later play restarts at row 0.
- Write row 1 during WAIT of row 0 → the new value is applied at row 1. Pulse rst_active_low low mid-WAIT → all outputs at reset values after one clk.

Source files
------------

// File: rtl/tracker_pkg.sv
// Shared state type, row-word codes and the MIDI-note to DDS phase-increment table
// for the tracker row sequencer (increments assume a 100 MHz DDS clock).
package tracker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    APPLY = 2'd2,
    WAIT  = 2'd3
  } seq_state_t;

  localparam logic [7:0] ROW_HOLD     = 8'h00;
  localparam logic [7:0] ROW_NOTE_OFF = 8'hFF;

  localparam real DDS_CLK_HZ = 100.0e6;

  // Equal-tempered pitch, A4 = note 69 = 440 Hz, rounded to the nearest phase step.
  function automatic logic [0:127][31:0] build_note_inc();
    logic [0:127][31:0] tbl;
    real hz;
    for (int n = 0; n < 128; n++) begin
      hz = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0));
      tbl[n] = 32'($rtoi(hz * 4294967296.0 / DDS_CLK_HZ + 0.5));
    end
    return tbl;
  endfunction

  localparam logic [0:127][31:0] NOTE_INC = build_note_inc();

endpackage

// File: rtl/pattern_ram.sv
// Pattern storage: one write port, one registered read port; a same-address
// write and read in one cycle returns the old word.
module pattern_ram #(
  parameter int ROWS  = 64,
  parameter int ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             rd_en,
  input  logic [ROW_W-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  logic [7:0] mem [ROWS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/tracker_row_sequencer.sv
// Row-based pattern sequencer driving DDS freq_word and a note gate, one row per TEMPO sample ticks.
// Build option: define SEQ_LOOP_EN to loop the pattern forever instead of stopping after the last row.
module tracker_row_sequencer
  import tracker_pkg::*;
#(
  parameter int ROWS    = 64,
  parameter int ROW_W   = $clog2(ROWS),
  parameter int TEMPO_W = 16
) (
  input  logic               clk,
  input  logic               rst_active_low,
  input  logic               sample_tick,
  input  logic               play,
  input  logic               stop,
  input  logic [TEMPO_W-1:0] tempo,
  input  logic               wr_en,
  input  logic [ROW_W-1:0]   wr_addr,
  input  logic [7:0]         wr_data,
  output logic [31:0]        freq_word,
  output logic               note_gate,
  output logic [ROW_W-1:0]   row_idx,
  output logic               row_strobe,
  output logic               busy
);

  seq_state_t         state;
  logic [ROW_W-1:0]   row_ptr;
  logic [TEMPO_W-1:0] tick_cnt;
  logic               play_q;
  logic [7:0]         row_word;

  pattern_ram #(
    .ROWS  (ROWS),
    .ROW_W (ROW_W)
  ) u_pattern_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (state == FETCH),
    .rd_addr (row_ptr),
    .rd_data (row_word)
  );

  // play is registered once before the FSM acts on it; a concurrent stop cancels it.
  always_ff @(posedge clk) begin
    if (!rst_active_low) begin
      state      <= IDLE;
      row_ptr    <= '0;
      tick_cnt   <= '0;
      play_q     <= 1'b0;
      freq_word  <= '0;
      note_gate  <= 1'b0;
      row_idx    <= '0;
      row_strobe <= 1'b0;
      busy       <= 1'b0;
    end else begin
      row_strobe <= 1'b0;
      play_q     <= play && !stop && (state == IDLE);
      if (stop) begin
        state     <= IDLE;
        busy      <= 1'b0;
        note_gate <= 1'b0;
        freq_word <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (play_q) begin
              state   <= FETCH;
              busy    <= 1'b1;
              row_ptr <= '0;
            end
          end
          FETCH: begin
            state <= APPLY;
          end
          APPLY: begin
            case (row_word)
              ROW_HOLD: ;
              ROW_NOTE_OFF: note_gate <= 1'b0;
              default: begin
                if (row_word[7]) begin
                  note_gate <= 1'b1;
                  freq_word <= NOTE_INC[row_word[6:0]];
                end
              end
            endcase
            row_idx    <= row_ptr;
            row_strobe <= 1'b1;
            tick_cnt   <= (tempo == '0) ? TEMPO_W'(1) : tempo;
            state      <= WAIT;
          end
          WAIT: begin
            if (sample_tick) begin
              if (tick_cnt == TEMPO_W'(1)) begin
`ifdef SEQ_LOOP_EN
                row_ptr <= row_ptr + ROW_W'(1);
                state   <= FETCH;
`else
                if (row_ptr == ROW_W'(ROWS - 1)) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  note_gate <= 1'b0;
                  freq_word <= '0;
                end else begin
                  row_ptr <= row_ptr + ROW_W'(1);
                  state   <= FETCH;
                end
`endif
              end else begin
                tick_cnt <= tick_cnt - TEMPO_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tracker_row_sequencer.sv
// Self-checking bench for tracker_row_sequencer (ROWS = 4): randomized patterns and
// tempos checked against a row-level reference model; honours SEQ_LOOP_EN like the design.
module tb_tracker_row_sequencer;

  localparam int ROWS    = 4;
  localparam int ROW_W   = 2;
  localparam int TEMPO_W = 16;

  logic               clk = 1'b0;
  logic               rst_active_low;
  logic               sample_tick;
  logic               play;
  logic               stop;
  logic [TEMPO_W-1:0] tempo;
  logic               wr_en;
  logic [ROW_W-1:0]   wr_addr;
  logic [7:0]         wr_data;
  logic [31:0]        freq_word;
  logic               note_gate;
  logic [ROW_W-1:0]   row_idx;
  logic               row_strobe;
  logic               busy;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;

  // Reference model: pattern contents and the outputs the sequencer should present
  logic [7:0]  m_mem [ROWS];
  logic [31:0] m_freq;
  logic        m_gate;

  always #5 clk = ~clk;

  tracker_row_sequencer #(
    .ROWS    (ROWS),
    .TEMPO_W (TEMPO_W)
  ) dut (
    .clk            (clk),
    .rst_active_low (rst_active_low),
    .sample_tick    (sample_tick),
    .play           (play),
    .stop           (stop),
    .tempo          (tempo),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .freq_word      (freq_word),
    .note_gate      (note_gate),
    .row_idx        (row_idx),
    .row_strobe     (row_strobe),
    .busy           (busy)
  );

  function automatic logic [31:0] ref_note_inc(input int n);
    real hz;
    hz = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0));
    return 32'($rtoi(hz * 4294967296.0 / 1.0e8 + 0.5));
  endfunction

  function automatic logic [7:0] rand_word();
    case ($urandom_range(3))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return {1'b1, 7'($urandom_range(126))};
      default: return {1'b0, 7'($urandom_range(127, 1))};
    endcase
  endfunction

  task automatic model_apply(input int r);
    logic [7:0] w;
    w = m_mem[r];
    if (w == 8'hFF) begin
      m_gate = 1'b0;
    end else if (w[7]) begin
      m_gate = 1'b1;
      m_freq = ref_note_inc(int'(w[6:0]));
    end
  endtask

  // One clock with the given sample_tick; outputs are observed 1 unit after the edge
  task automatic clk_cycle(input logic tick);
    sample_tick = tick;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    if (row_strobe === 1'b1) strobe_cnt++;
  endtask

  task automatic wait_strobe(output bit got, input bit noisy);
    int c0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      c0 = strobe_cnt;
      clk_cycle(noisy ? 1'($urandom_range(1)) : 1'b0);
      if (strobe_cnt != c0) got = 1'b1;
    end
  endtask

  task automatic write_row(input int a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = ROW_W'(a);
    wr_data = d;
    clk_cycle(1'b0);
    wr_en   = 1'b0;
    m_mem[a] = d;
  endtask

  task automatic start_play();
    play = 1'b1;
    clk_cycle(1'b0);
    play = 1'b0;
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    clk_cycle(1'b0);
    stop = 1'b0;
    m_freq = '0;
    m_gate = 1'b0;
  endtask

  task automatic test_reset();
    rst_active_low = 1'b0;
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    rst_active_low = 1'b1;
    clk_cycle(1'b0);
    m_freq = '0;
    m_gate = 1'b0;
    checks++; if (freq_word !== 32'h0) begin errors++; $display("[TB] FAIL reset_freq: got %h expected 0", freq_word); end
    checks++; if (note_gate !== 1'b0) begin errors++; $display("[TB] FAIL reset_gate: got %b expected 0", note_gate); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (row_idx !== '0) begin errors++; $display("[TB] FAIL reset_row_idx: got %0d expected 0", row_idx); end
    checks++; if (row_strobe !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobe: got %b expected 0", row_strobe); end
    strobe_cnt = 0;
    repeat (100) clk_cycle(1'($urandom_range(1)));
    checks++; if (strobe_cnt != 0) begin errors++; $display("[TB] FAIL idle_strobes: got %0d expected 0", strobe_cnt); end
    checks++; if (busy !== 1'b0 || note_gate !== 1'b0 || freq_word !== 32'h0) begin
      errors++; $display("[TB] FAIL idle_outputs: got busy %b gate %b freq %h expected 0 0 0", busy, note_gate, freq_word);
    end
  endtask

  task automatic test_note_decode();
    int c0;
    bit got;
    write_row(0, 8'hC5);
    write_row(1, 8'h00);
    write_row(2, 8'hFF);
    write_row(3, 8'h81);
    tempo = TEMPO_W'(2);
    start_play();
    c0 = strobe_cnt;
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    checks++; if (strobe_cnt != c0) begin errors++; $display("[TB] FAIL latency_early: got %0d strobes expected 0", strobe_cnt - c0); end
    clk_cycle(1'b0);
    checks++; if (row_strobe !== 1'b1) begin errors++; $display("[TB] FAIL latency_strobe: got %b expected 1", row_strobe); end
    checks++; if (freq_word !== 32'h0000_49D2) begin errors++; $display("[TB] FAIL a440_freq: got %h expected 000049d2", freq_word); end
    checks++; if (note_gate !== 1'b1) begin errors++; $display("[TB] FAIL a440_gate: got %b expected 1", note_gate); end
    checks++; if (row_idx !== 2'd0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL row0_idx_busy: got %0d %b expected 0 1", row_idx, busy); end
    clk_cycle(1'b1);
    checks++; if (row_strobe !== 1'b0) begin errors++; $display("[TB] FAIL strobe_width: got %b expected 0", row_strobe); end
    clk_cycle(1'b1);
    wait_strobe(got, 1'b0);
    checks++; if (!got || row_idx !== 2'd1) begin errors++; $display("[TB] FAIL hold_row: got strobe %b idx %0d expected 1 1", got, row_idx); end
    checks++; if (freq_word !== 32'h0000_49D2 || note_gate !== 1'b1) begin
      errors++; $display("[TB] FAIL hold_outputs: got %h %b expected 000049d2 1", freq_word, note_gate);
    end
    clk_cycle(1'b1);
    clk_cycle(1'b1);
    wait_strobe(got, 1'b0);
    checks++; if (!got || row_idx !== 2'd2) begin errors++; $display("[TB] FAIL noteoff_row: got strobe %b idx %0d expected 1 2", got, row_idx); end
    checks++; if (freq_word !== 32'h0000_49D2 || note_gate !== 1'b0) begin
      errors++; $display("[TB] FAIL noteoff_outputs: got %h %b expected 000049d2 0", freq_word, note_gate);
    end
    stop_pulse();
  endtask

  task automatic test_tempo_zero();
    int c0, ticks, nrows;
    bit got;
    for (int r = 0; r < ROWS; r++) write_row(r, rand_word());
    tempo = '0;
    start_play();
    wait_strobe(got, 1'b1);
    model_apply(0);
    checks++; if (!got || row_idx !== 2'd0) begin errors++; $display("[TB] FAIL t0_first: got strobe %b idx %0d expected 1 0", got, row_idx); end
    c0 = strobe_cnt;
    ticks = 0;
`ifdef SEQ_LOOP_EN
    nrows = 6;
`else
    nrows = ROWS - 1;
`endif
    for (int i = 1; i <= nrows; i++) begin
      clk_cycle(1'b1);
      ticks++;
      wait_strobe(got, 1'b0);
      model_apply(i % ROWS);
      checks++; if (!got || int'(row_idx) != i % ROWS) begin
        errors++; $display("[TB] FAIL t0_row: got strobe %b idx %0d expected 1 %0d", got, row_idx, i % ROWS);
      end
      checks++; if (freq_word !== m_freq || note_gate !== m_gate) begin
        errors++; $display("[TB] FAIL t0_outputs row %0d: got %h %b expected %h %b", i % ROWS, freq_word, note_gate, m_freq, m_gate);
      end
    end
    checks++; if (strobe_cnt - c0 != ticks) begin errors++; $display("[TB] FAIL t0_count: got %0d strobes expected %0d", strobe_cnt - c0, ticks); end
    stop_pulse();
  endtask

  task automatic test_pattern_end();
    int c0;
    bit got;
    for (int r = 0; r < ROWS; r++) write_row(r, rand_word());
    tempo = TEMPO_W'(1);
    start_play();
    wait_strobe(got, 1'b0);
    checks++; if (!got || row_idx !== 2'd0) begin errors++; $display("[TB] FAIL end_first: got strobe %b idx %0d expected 1 0", got, row_idx); end
    for (int t = 1; t <= 5; t++) begin
      c0 = strobe_cnt;
      clk_cycle(1'b1);
`ifdef SEQ_LOOP_EN
      wait_strobe(got, 1'b0);
      checks++; if (!got || int'(row_idx) != t % ROWS || busy !== 1'b1) begin
        errors++; $display("[TB] FAIL loop_row: got strobe %b idx %0d busy %b expected 1 %0d 1", got, row_idx, busy, t % ROWS);
      end
`else
      if (t < ROWS) begin
        wait_strobe(got, 1'b0);
        checks++; if (!got || int'(row_idx) != t) begin
          errors++; $display("[TB] FAIL end_row: got strobe %b idx %0d expected 1 %0d", got, row_idx, t);
        end
      end else begin
        if (t == ROWS) begin
          checks++; if (busy !== 1'b0 || note_gate !== 1'b0 || freq_word !== 32'h0) begin
            errors++; $display("[TB] FAIL end_idle: got busy %b gate %b freq %h expected 0 0 0", busy, note_gate, freq_word);
          end
        end
        repeat (4) clk_cycle(1'b0);
        checks++; if (strobe_cnt != c0) begin errors++; $display("[TB] FAIL end_no_strobe tick %0d: got %0d strobes expected 0", t, strobe_cnt - c0); end
      end
`endif
    end
    stop_pulse();
  endtask

  task automatic test_stop_play();
    int c0;
    bit got;
    for (int r = 0; r < ROWS; r++) write_row(r, rand_word());
    tempo = TEMPO_W'(1);
    start_play();
    wait_strobe(got, 1'b1);
    tempo = TEMPO_W'(3);
    clk_cycle(1'b1);
    wait_strobe(got, 1'b0);
    checks++; if (!got || row_idx !== 2'd1) begin errors++; $display("[TB] FAIL sp_row1: got strobe %b idx %0d expected 1 1", got, row_idx); end
    clk_cycle(1'b1);
    stop = 1'b1;
    play = 1'b1;
    clk_cycle(1'b0);
    stop = 1'b0;
    play = 1'b0;
    m_freq = '0;
    m_gate = 1'b0;
    checks++; if (busy !== 1'b0 || note_gate !== 1'b0 || freq_word !== 32'h0 || row_strobe !== 1'b0) begin
      errors++; $display("[TB] FAIL sp_stop: got busy %b gate %b freq %h strobe %b expected 0 0 0 0", busy, note_gate, freq_word, row_strobe);
    end
    checks++; if (row_idx !== 2'd1) begin errors++; $display("[TB] FAIL sp_row_held: got %0d expected 1", row_idx); end
    c0 = strobe_cnt;
    repeat (6) clk_cycle(1'($urandom_range(1)));
    checks++; if (strobe_cnt != c0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL sp_play_ignored: got %0d strobes busy %b expected 0 0", strobe_cnt - c0, busy);
    end
    start_play();
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    model_apply(0);
    checks++; if (row_strobe !== 1'b1 || row_idx !== 2'd0) begin
      errors++; $display("[TB] FAIL sp_restart: got strobe %b idx %0d expected 1 0", row_strobe, row_idx);
    end
    checks++; if (freq_word !== m_freq || note_gate !== m_gate) begin
      errors++; $display("[TB] FAIL sp_restart_out: got %h %b expected %h %b", freq_word, note_gate, m_freq, m_gate);
    end
    stop_pulse();
  endtask

  task automatic test_write_during_wait();
    bit got;
    write_row(0, {1'b1, 7'($urandom_range(126))});
    write_row(1, 8'hA0);
    tempo = TEMPO_W'(2);
    start_play();
    wait_strobe(got, 1'b0);
    write_row(1, 8'hB0);
    clk_cycle(1'b1);
    clk_cycle(1'b1);
    // This write lands on the same edge the row-1 read does, so the old word must win
    wr_en   = 1'b1;
    wr_addr = 2'd1;
    wr_data = 8'hC0;
    clk_cycle(1'b0);
    wr_en   = 1'b0;
    model_apply(1);
    m_mem[1] = 8'hC0;
    wait_strobe(got, 1'b0);
    checks++; if (!got || row_idx !== 2'd1) begin errors++; $display("[TB] FAIL wr_row1: got strobe %b idx %0d expected 1 1", got, row_idx); end
    checks++; if (freq_word !== m_freq || note_gate !== m_gate) begin
      errors++; $display("[TB] FAIL wr_new_value: got %h %b expected %h %b", freq_word, note_gate, m_freq, m_gate);
    end
    clk_cycle(1'b1);
    rst_active_low = 1'b0;
    clk_cycle(1'b0);
    rst_active_low = 1'b1;
    m_freq = '0;
    m_gate = 1'b0;
    checks++; if (freq_word !== 32'h0 || note_gate !== 1'b0 || busy !== 1'b0 || row_idx !== 2'd0 || row_strobe !== 1'b0) begin
      errors++; $display("[TB] FAIL midrun_reset: got %h %b %b %0d %b expected 0 0 0 0 0", freq_word, note_gate, busy, row_idx, row_strobe);
    end
    start_play();
    wait_strobe(got, 1'b0);
    model_apply(0);
    checks++; if (!got || freq_word !== m_freq || note_gate !== m_gate) begin
      errors++; $display("[TB] FAIL ram_kept: got strobe %b %h %b expected 1 %h %b", got, freq_word, note_gate, m_freq, m_gate);
    end
    stop_pulse();
  endtask

  task automatic test_random();
    int c0, need, tempo_cur, nrows;
    bit got;
`ifdef SEQ_LOOP_EN
    nrows = ROWS + 2;
`else
    nrows = ROWS;
`endif
    for (int iter = 0; iter < 4; iter++) begin
      for (int r = 0; r < ROWS; r++) write_row(r, rand_word());
      stop_pulse();
      tempo_cur = $urandom_range(3);
      tempo = TEMPO_W'(tempo_cur);
      start_play();
      wait_strobe(got, 1'b1);
      for (int k = 0; k < nrows; k++) begin
        model_apply(k % ROWS);
        checks++; if (!got || int'(row_idx) != k % ROWS || busy !== 1'b1) begin
          errors++; $display("[TB] FAIL rand_row: got strobe %b idx %0d busy %b expected 1 %0d 1", got, row_idx, busy, k % ROWS);
        end
        checks++; if (freq_word !== m_freq || note_gate !== m_gate) begin
          errors++; $display("[TB] FAIL rand_outputs row %0d: got %h %b expected %h %b", k % ROWS, freq_word, note_gate, m_freq, m_gate);
        end
        need = (tempo_cur == 0) ? 1 : tempo_cur;
        tempo_cur = $urandom_range(3);
        tempo = TEMPO_W'(tempo_cur);
        c0 = strobe_cnt;
        for (int j = 0; j < need - 1; j++) begin
          repeat ($urandom_range(2)) clk_cycle(1'b0);
          clk_cycle(1'b1);
        end
        repeat ($urandom_range(2)) clk_cycle(1'b0);
        checks++; if (strobe_cnt != c0 || busy !== 1'b1) begin
          errors++; $display("[TB] FAIL rand_early_row: got %0d strobes busy %b expected 0 1", strobe_cnt - c0, busy);
        end
        clk_cycle(1'b1);
`ifndef SEQ_LOOP_EN
        if (k == ROWS - 1) begin
          m_freq = '0;
          m_gate = 1'b0;
          checks++; if (busy !== 1'b0 || note_gate !== 1'b0 || freq_word !== 32'h0) begin
            errors++; $display("[TB] FAIL rand_end: got busy %b gate %b freq %h expected 0 0 0", busy, note_gate, freq_word);
          end
          repeat (5) clk_cycle(1'($urandom_range(1)));
          checks++; if (strobe_cnt != c0) begin errors++; $display("[TB] FAIL rand_end_strobe: got %0d expected 0", strobe_cnt - c0); end
          break;
        end
`endif
        wait_strobe(got, 1'b1);
      end
    end
    stop_pulse();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_active_low = 1'b0;
    sample_tick    = 1'b0;
    play           = 1'b0;
    stop           = 1'b0;
    tempo          = '0;
    wr_en          = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    m_freq         = '0;
    m_gate         = 1'b0;
    test_reset();
    test_note_decode();
    test_tempo_zero();
    test_pattern_end();
    test_stop_play();
    test_write_during_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
